// File: rtl/secded_lock_pkg.sv
// rtl/secded_lock_pkg.sv - shared types and codeword-layout helpers for the key-locked SEC-DED pipe
package secded_lock_pkg;

    typedef enum logic [1:0] {
        ERR_CLEAN  = 2'b00,
        ERR_CORR   = 2'b01,
        ERR_UNCORR = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_LOAD,
        ST_ARMED
    } key_state_e;

    localparam int MAX_POS = 1024;

    function automatic int chk_width(input int dataW);
        return $clog2(dataW + $clog2(dataW) + 1) + 1;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Codeword position of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < MAX_POS; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/locked_secded_pipe_if.sv
// rtl/locked_secded_pipe_if.sv - input/output word handshake bundle for locked_secded_pipe
interface locked_secded_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_err;

    modport master (
        output in_valid, in_data, in_chk, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_chk, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational extended-Hamming syndrome of data plus received check bits
module secded_syndrome
    import secded_lock_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = chk_width(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output logic [CHK_W-1:0]  syn
);
    localparam int HW = CHK_W - 1;

    logic [HW-1:0] posTerm [DATA_W];
    logic [HW-1:0] hamm;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
        localparam logic [HW-1:0] POS = HW'(data_pos(gi));
        assign posTerm[gi] = data[gi] ? POS : '0;
    end

    always_comb begin
        hamm = '0;
        for (int i = 0; i < DATA_W; i++) hamm = hamm ^ posTerm[i];
    end

    // Overall parity folds in every received check bit, including itself.
    assign syn = {(^data) ^ (^chk), hamm ^ chk[HW-1:0]};
endmodule

// File: rtl/locked_secded_pipe.sv
// rtl/locked_secded_pipe.sv - two-stage key-locked SEC-DED decoder with serial key load
// Optional: define SECDED_ERR_CNT_EN to build the saturating corr/uncorr counters.
module locked_secded_pipe
    import secded_lock_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              KEY_W    = 32,
    parameter logic [KEY_W-1:0] LOCK_KEY = '0,
    parameter int              CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    locked_secded_pipe_if.slave  bus,
    input  logic                 key_load,
    input  logic                 key_bit_valid,
    input  logic                 key_bit,
    output logic                 key_armed,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);
    localparam int CHK_W = chk_width(DATA_W);
    localparam int NPOS  = DATA_W + CHK_W - 1;
    localparam int BC_W  = $clog2(KEY_W + 1);

    key_state_e        state, stateNext;
    logic [KEY_W-1:0]  keyReg;
    logic [BC_W-1:0]   bitCnt;
    logic [KEY_W-1:0]  kEff;
    logic [CHK_W-1:0]  pert;
    logic [CHK_W-1:0]  rawSyn;

    logic              s1Valid, s2Valid;
    logic [CHK_W-1:0]  s1Syn;
    logic [DATA_W-1:0] s1Data, outData, decData, flipMask;
    err_e              errQ, decErr;
    logic              s2Free, inFire;
    logic [CHK_W-2:0]  ps;
    logic              ov;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOCKED;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (state == ST_LOAD && key_bit_valid && int'(bitCnt) == KEY_W - 1)
            stateNext = ST_ARMED;
        if (key_load)
            stateNext = ST_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keyReg <= '0;
            bitCnt <= '0;
        end else if (key_load) begin
            bitCnt <= '0;
        end else if (state == ST_LOAD && key_bit_valid) begin
            keyReg <= {key_bit, keyReg[KEY_W-1:1]};
            bitCnt <= bitCnt + 1'b1;
        end
    end

    assign key_armed = (state == ST_ARMED);
    assign kEff      = keyReg ^ LOCK_KEY;

    // Key bits fold onto syndrome bits modulo CHK_W.
    always_comb begin
        pert = '0;
        for (int j = 0; j < KEY_W; j++)
            pert[j % CHK_W] = pert[j % CHK_W] ^ kEff[j];
    end

    secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
        .data (bus.in_data),
        .chk  (bus.in_chk),
        .syn  (rawSyn)
    );

    assign s2Free       = !s2Valid || bus.out_ready;
    assign bus.in_ready = (state != ST_LOAD) && (!s1Valid || s2Free);
    assign inFire       = bus.in_valid && bus.in_ready;

    assign ps = s1Syn[CHK_W-2:0];
    assign ov = s1Syn[CHK_W-1];

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flip
        localparam int POS = data_pos(gi);
        assign flipMask[gi] = (int'(ps) == POS);
    end

    always_comb begin
        decData = s1Data;
        decErr  = ERR_CLEAN;
        if (!ov) begin
            if (ps != '0) decErr = ERR_UNCORR;
        end else if (int'(ps) > NPOS) begin
            decErr = ERR_UNCORR;
        end else begin
            decErr  = ERR_CORR;
            decData = s1Data ^ flipMask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Syn   <= '0;
            s1Data  <= '0;
            s2Valid <= 1'b0;
            outData <= '0;
            errQ    <= ERR_CLEAN;
        end else begin
            if (!s1Valid || s2Free) begin
                s1Valid <= inFire;
                if (inFire) begin
                    s1Syn  <= rawSyn ^ pert;
                    s1Data <= bus.in_data;
                end
            end
            if (s2Free) begin
                s2Valid <= s1Valid;
                if (s1Valid) begin
                    outData <= decData;
                    errQ    <= decErr;
                end
            end
        end
    end

    assign bus.out_valid = s2Valid;
    assign bus.out_data  = outData;
    assign bus.out_err   = errQ;

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_W-1:0] corrQ, uncorrQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            corrQ   <= '0;
            uncorrQ <= '0;
        end else if (s2Valid && bus.out_ready) begin
            if (errQ == ERR_CORR && corrQ != '1)     corrQ   <= corrQ + 1'b1;
            if (errQ == ERR_UNCORR && uncorrQ != '1) uncorrQ <= uncorrQ + 1'b1;
        end
    end

    assign corr_cnt   = corrQ;
    assign uncorr_cnt = uncorrQ;
`else
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;
`endif
endmodule
